mem_bus_arbiter: RTL and testbench

- Shares the single C2 memory bus (line address, 16-bit bidirectional data, 2-bit bidirectional command) between NUM_REQ line-level requesters, e.g. the instruction and data caches.
- Arbitrates round-robin, runs one full READ or WRITE bus transaction per grant, and serialises/deserialises the 128-bit line into 8 bus beats.
- Returns the read line or write completion to the granted requester.
- A watchdog flags a memory that never responds.

---
 rtl/mem_bus_pkg.sv | 33 +++
 rtl/rr_arbiter.sv | 43 ++++
 rtl/mem_bus_arbiter.sv | 166 ++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_pkg.sv
// Shared constants and types for the C2 memory-bus arbiter.
package mem_bus_pkg;

    // C2 command encodings on the shared mem_cmd bus
    localparam logic [1:0] CMD_NOP      = 2'd0;
    localparam logic [1:0] CMD_RESPONSE = 2'd1;
    localparam logic [1:0] CMD_READ     = 2'd2;
    localparam logic [1:0] CMD_WRITE    = 2'd3;

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWait,
        StXfer,
        StDone
    } state_e;

    // Widths for the default geometry (16-byte line, 16-bit bus, 1000-cycle watchdog)
    localparam int unsigned BEATS_PER_LINE = 8;
    localparam int unsigned BEAT_IDX_W     = 3;
    localparam int unsigned WAIT_CNT_W     = $clog2(1000 + 1);

    function automatic int unsigned beats_per_line(int unsigned line_bytes,
                                                   int unsigned bus_bits);
        return (line_bytes * 8) / bus_bits;
    endfunction

    // Index width that stays at least one bit for single-entry ranges
    function automatic int unsigned idx_width(int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin winner select with a pointer that advances past each completed winner.
module rr_arbiter
    import mem_bus_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned ID_W    = idx_width(NUM_REQ)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_REQ-1:0]  valid,
    input  logic                done,
    input  logic [ID_W-1:0]     done_id,
    output logic [ID_W-1:0]     grant_id,
    output logic                any_valid
);

    logic [ID_W-1:0] ptr_q;
    logic [ID_W-1:0] cand;

    // First valid index at or after the pointer, wrapping around
    always_comb begin
        grant_id  = '0;
        any_valid = 1'b0;
        cand      = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = ID_W'((32'(ptr_q) + i) % NUM_REQ);
            if (!any_valid && valid[cand]) begin
                any_valid = 1'b1;
                grant_id  = cand;
            end
        end
    end

    // Pointer moves to the requester after the one just served
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q <= '0;
        end else if (done) begin
            ptr_q <= (done_id == ID_W'(NUM_REQ - 1)) ? '0 : done_id + ID_W'(1);
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates line requests onto the C2 memory bus and (de)serialises lines into bus beats.
module mem_bus_arbiter
    import mem_bus_pkg::*;
#(
    parameter int unsigned NUM_REQ         = 2,
    parameter int unsigned ADDR_W          = 15,
    parameter int unsigned BUS_SIZE        = 16,
    parameter int unsigned CACHE_LINE_SIZE = 16,
    parameter int unsigned TIMEOUT_CYCLES  = 1000
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [NUM_REQ-1:0]                  req_valid,
    input  logic [NUM_REQ-1:0]                  req_write,
    input  logic [NUM_REQ*ADDR_W-1:0]           req_addr,
    input  logic [NUM_REQ*CACHE_LINE_SIZE*8-1:0] req_wdata,
    output logic [NUM_REQ-1:0]                  req_done,
    output logic [CACHE_LINE_SIZE*8-1:0]        rdata,
    output logic                                timeout_err,
    output logic                                busy,
    output logic [ADDR_W-1:0]                   mem_addr,
    inout  wire  [BUS_SIZE-1:0]                 mem_data,
    inout  wire  [1:0]                          mem_cmd
);

    localparam int unsigned LINE_W = CACHE_LINE_SIZE * 8;
    localparam int unsigned BEATS  = beats_per_line(CACHE_LINE_SIZE, BUS_SIZE);
    localparam int unsigned BEAT_W = idx_width(BEATS);
    localparam int unsigned WCNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned ID_W   = idx_width(NUM_REQ);
    // The last read beat goes straight into rdata, so only BEATS-1 beats are buffered
    localparam int unsigned RB_W   = LINE_W - BUS_SIZE;

    state_e              state_q, state_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic                wr_q, wr_d;
    logic                abort_q, abort_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [LINE_W-1:0]   wbuf_q, wbuf_d;
    logic [RB_W-1:0]     rbuf_q, rbuf_d;
    logic [LINE_W-1:0]   rdata_q, rdata_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic [WCNT_W-1:0]   wcnt_q, wcnt_d;

    logic                resp_seen;
    logic                any_valid;
    logic [ID_W-1:0]     grant_id;
    logic                in_done;

    assign resp_seen = (mem_cmd == CMD_RESPONSE);
    assign in_done   = (state_q == StDone);

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_arbiter (
        .clk       (clk),
        .reset     (reset),
        .valid     (req_valid),
        .done      (in_done),
        .done_id   (id_q),
        .grant_id  (grant_id),
        .any_valid (any_valid)
    );

    // Next-state and datapath for grant / issue / wait / beat transfer / completion
    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        wr_d    = wr_q;
        abort_d = abort_q;
        addr_d  = addr_q;
        wbuf_d  = wbuf_q;
        rbuf_d  = rbuf_q;
        rdata_d = rdata_q;
        beat_d  = beat_q;
        wcnt_d  = wcnt_q;
        unique case (state_q)
            StIdle: begin
                // A RESPONSE here is a leftover transfer from before reset; let it drain
                if (any_valid && !resp_seen) begin
                    state_d = StIssue;
                    id_d    = grant_id;
                    wr_d    = req_write[grant_id];
                    addr_d  = req_addr[32'(grant_id) * ADDR_W +: ADDR_W];
                    wbuf_d  = req_wdata[32'(grant_id) * LINE_W +: LINE_W];
                    abort_d = 1'b0;
                end
            end
            StIssue: begin
                wcnt_d  = '0;
                state_d = StWait;
            end
            StWait: begin
                if (resp_seen) begin
                    state_d = StXfer;
                    beat_d  = BEAT_W'(1);
                    rbuf_d  = {mem_data, rbuf_q[RB_W-1:BUS_SIZE]};
                    wbuf_d  = wbuf_q >> BUS_SIZE;
                end else if (wcnt_q == WCNT_W'(TIMEOUT_CYCLES)) begin
                    state_d = StDone;
                    abort_d = 1'b1;
                end else begin
                    wcnt_d = wcnt_q + WCNT_W'(1);
                end
            end
            StXfer: begin
                rbuf_d = {mem_data, rbuf_q[RB_W-1:BUS_SIZE]};
                wbuf_d = wbuf_q >> BUS_SIZE;
                if (beat_q == BEAT_W'(BEATS - 1)) begin
                    state_d = StDone;
                    if (!wr_q) begin
                        rdata_d = {mem_data, rbuf_q};
                    end
                end else begin
                    beat_d = beat_q + BEAT_W'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers; reset releases the buses immediately via state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            id_q    <= '0;
            wr_q    <= 1'b0;
            abort_q <= 1'b0;
            addr_q  <= '0;
            wbuf_q  <= '0;
            rbuf_q  <= '0;
            rdata_q <= '0;
            beat_q  <= '0;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            wr_q    <= wr_d;
            abort_q <= abort_d;
            addr_q  <= addr_d;
            wbuf_q  <= wbuf_d;
            rbuf_q  <= rbuf_d;
            rdata_q <= rdata_d;
            beat_q  <= beat_d;
            wcnt_q  <= wcnt_d;
        end
    end

    assign busy        = (state_q != StIdle);
    assign req_done    = in_done ? (NUM_REQ'(1) << id_q) : '0;
    assign timeout_err = in_done && abort_q;
    assign rdata       = rdata_q;
    assign mem_addr    = addr_q;

    // Command only during ISSUE; data only on writes, from WAIT entry through the last beat
    assign mem_cmd  = (state_q == StIssue) ? (wr_q ? CMD_WRITE : CMD_READ) : 2'bz;
    assign mem_data = (wr_q && (state_q == StWait || state_q == StXfer)) ?
                      wbuf_q[BUS_SIZE-1:0] : {BUS_SIZE{1'bz}};

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter with a behavioural C2 memory stub.
module tb_mem_bus_arbiter;
    import mem_bus_pkg::*;

    localparam int unsigned TO      = 200;
    localparam int unsigned RESP    = 100;
    localparam int          LAT_OK  = RESP + 8;   // ISSUE to DONE, normal
    localparam int          LAT_TO  = TO + 2;     // ISSUE to DONE, aborted
    localparam logic [127:0] LINE5 = 128'h00ff_00ee_00dd_00cc_00bb_00aa_0099_0001;
    localparam logic [127:0] WLINE = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_0F0F_F0F0;
    localparam logic [127:0] XLINE = 128'h1111_2222_3333_4444_5555_6666_7777_8888;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [1:0]     req_valid = '0;
    logic [1:0]     req_write = '0;
    logic [29:0]    req_addr = '0;
    logic [255:0]   req_wdata = '0;
    logic [1:0]     req_done;
    logic [127:0]   rdata;
    logic           timeout_err;
    logic           busy;
    logic [14:0]    mem_addr;
    wire  [15:0]    mem_data;
    wire  [1:0]     mem_cmd;

    logic           stub_cmd_oe = 1'b0;
    logic           stub_data_oe = 1'b0;
    logic [15:0]    stub_data = '0;
    logic           stub_busy = 1'b0;
    logic           stub_silent = 1'b0;
    logic [127:0]   mem [64];

    assign mem_cmd  = stub_cmd_oe ? CMD_RESPONSE : 2'bz;
    assign mem_data = stub_data_oe ? stub_data : 16'bz;

    typedef struct {
        int           id;
        bit           wr;
        logic [14:0]  addr;
        logic [127:0] line;
        bit           abort;
    } exp_t;

    exp_t         exp_q[$];
    int           done_cycles[$];
    logic [127:0] exp_rdata = '0;
    int           hold_cnt[2] = '{0, 0};
    int           cyc = 0;
    int           issue_cyc = 0;
    int           n_cmp = 0;
    int           n_err = 0;

    mem_bus_arbiter #(
        .NUM_REQ         (2),
        .ADDR_W          (15),
        .BUS_SIZE        (16),
        .CACHE_LINE_SIZE (16),
        .TIMEOUT_CYCLES  (TO)
    ) dut (
        .clk         (clk),
        .reset       (rst_n),
        .req_valid   (req_valid),
        .req_write   (req_write),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_done    (req_done),
        .rdata       (rdata),
        .timeout_err (timeout_err),
        .busy        (busy),
        .mem_addr    (mem_addr),
        .mem_data    (mem_data),
        .mem_cmd     (mem_cmd)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string name, logic [127:0] act, logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(string name, string msg);
        n_cmp++;
        n_err++;
        $display("FAIL %s: %s (cycle %0d)", name, msg, cyc);
    endtask

    task automatic push_exp(int id, bit wr, logic [14:0] addr, logic [127:0] line, bit abort);
        exp_t e;
        e.id = id; e.wr = wr; e.addr = addr; e.line = line; e.abort = abort;
        exp_q.push_back(e);
    endtask

    task automatic request(int id, bit wr, logic [14:0] addr, logic [127:0] line, bit abort);
        push_exp(id, wr, addr, line, abort);
        req_write[id]            = wr;
        req_addr[id*15 +: 15]    = addr;
        req_wdata[id*128 +: 128] = line;
        req_valid[id]            = 1'b1;
    endtask

    task automatic wait_issue(int budget);
        int n = 0;
        @(negedge clk);
        while (!(mem_cmd == CMD_READ || mem_cmd == CMD_WRITE) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) fail("issue_timeout", "no command issued within budget");
    endtask

    task automatic drain(int budget);
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) begin
            fail("drain_timeout", $sformatf("%0d responses still outstanding", exp_q.size()));
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    // Memory stub: answers RESP cycles after a command with eight RESPONSE beats
    initial begin : stub
        logic [14:0]  a;
        logic [127:0] line;
        bit           wr;
        for (int i = 0; i < 64; i++) mem[i] = '0;
        mem[5] = LINE5;
        forever begin
            @(negedge clk);
            if (!stub_silent && (mem_cmd == CMD_READ || mem_cmd == CMD_WRITE)) begin
                wr   = (mem_cmd == CMD_WRITE);
                a    = mem_addr;
                line = mem[a[5:0]];
                repeat (RESP) @(posedge clk);
                #1;
                stub_busy = 1'b1;
                for (int b = 0; b < 8; b++) begin
                    stub_cmd_oe = 1'b1;
                    if (!wr) begin
                        stub_data_oe = 1'b1;
                        stub_data    = line[16*b +: 16];
                    end
                    @(negedge clk);
                    if (wr) line[16*b +: 16] = mem_data;
                    @(posedge clk);
                    #1;
                end
                stub_cmd_oe  = 1'b0;
                stub_data_oe = 1'b0;
                stub_busy    = 1'b0;
                if (wr) mem[a[5:0]] = line;
            end
        end
    end

    // Monitor: checks issue cycles, bus release on reads, and pops on every req_done
    initial begin : monitor
        bit         prev_issue = 1'b0;
        logic [1:0] prev_done = '0;
        exp_t       e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_issue = 1'b0;
                prev_done  = '0;
                continue;
            end
            if (mem_cmd == CMD_READ || mem_cmd == CMD_WRITE) begin
                check("cmd_single_cycle", 128'(prev_issue), 128'(0));
                issue_cyc = cyc;
                if (exp_q.size() == 0) begin
                    fail("unexpected_issue", $sformatf("cmd %0d addr %0h", mem_cmd, mem_addr));
                end else begin
                    check("issue_cmd", 128'(mem_cmd), exp_q[0].wr ? 128'(CMD_WRITE) : 128'(CMD_READ));
                    check("issue_addr", 128'(mem_addr), 128'(exp_q[0].addr));
                end
                prev_issue = 1'b1;
            end else begin
                prev_issue = 1'b0;
            end
            if (busy && exp_q.size() != 0 && !exp_q[0].wr && !stub_data_oe) begin
                n_cmp++;
                if (mem_data != 16'h0) begin
                    n_err++;
                    $display("FAIL read_data_released: mem_data driven %0h (cycle %0d)", mem_data, cyc);
                end
            end
            if (req_done != 2'b00) begin
                check("done_single_cycle", 128'(prev_done), 128'(0));
                done_cycles.push_back(cyc);
                if (exp_q.size() == 0) begin
                    fail("unexpected_done", $sformatf("req_done %b", req_done));
                end else begin
                    e = exp_q.pop_front();
                    check("done_onehot", 128'(req_done), 128'(2'b01 << e.id));
                    check("timeout_flag", 128'(timeout_err), 128'(e.abort));
                    check("latency", 128'(cyc - issue_cyc), 128'(e.abort ? LAT_TO : LAT_OK));
                    if (!e.wr && !e.abort) begin
                        check("rdata", rdata, e.line);
                        exp_rdata = e.line;
                    end else begin
                        check("rdata_held", rdata, exp_rdata);
                    end
                end
                for (int i = 0; i < 2; i++) begin
                    if (req_done[i]) begin
                        if (hold_cnt[i] > 0) hold_cnt[i]--;
                        else req_valid[i] = 1'b0;
                    end
                end
            end else if (timeout_err) begin
                fail("stray_timeout", "timeout_err without req_done");
            end
            prev_done = req_done;
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL global_watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int n;
        // Reset values
        repeat (2) @(negedge clk);
        check("rst_req_done", 128'(req_done), 128'(0));
        check("rst_timeout", 128'(timeout_err), 128'(0));
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_rdata", rdata, 128'(0));
        check("rst_mem_addr", 128'(mem_addr), 128'(0));
        check("rst_mem_cmd", 128'(mem_cmd == CMD_READ || mem_cmd == CMD_WRITE), 128'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // Single read of a preloaded line; wdata lane is nonzero to expose a stray drive
        req_wdata[127:0] = XLINE;
        request(0, 1'b0, 15'd5, LINE5, 1'b0);
        drain(300);

        // Write a line, then read it back
        request(1, 1'b1, 15'h10, WLINE, 1'b0);
        drain(300);
        request(0, 1'b0, 15'h10, WLINE, 1'b0);
        drain(300);

        // Both valid from reset release: grants alternate 0,1,0,1
        rst_n = 1'b0;
        exp_rdata = '0;
        hold_cnt = '{1, 1};
        request(0, 1'b0, 15'd5, LINE5, 1'b0);
        request(1, 1'b0, 15'h10, WLINE, 1'b0);
        push_exp(0, 1'b0, 15'd5, LINE5, 1'b0);
        push_exp(1, 1'b0, 15'h10, WLINE, 1'b0);
        repeat (2) @(negedge clk);
        done_cycles.delete();
        rst_n = 1'b1;
        drain(700);
        check("b2b_count", 128'(done_cycles.size()), 128'(4));
        for (int i = 1; i < 4 && i < done_cycles.size(); i++)
            check("b2b_spacing", 128'(done_cycles[i] - done_cycles[i-1]), 128'(110));

        // Silent memory: watchdog aborts, rdata unchanged, next request served normally
        stub_silent = 1'b1;
        request(0, 1'b0, 15'd7, '0, 1'b1);
        drain(400);
        stub_silent = 1'b0;
        check("to_bus_released", 128'(mem_cmd == CMD_READ || mem_cmd == CMD_WRITE), 128'(0));
        request(1, 1'b0, 15'd5, LINE5, 1'b0);
        drain(300);

        // Reset mid-WAIT of a write: buses release at once, no grant until stub drains
        request(1, 1'b1, 15'h20, XLINE, 1'b0);
        wait_issue(20);
        repeat (50) @(posedge clk);
        #3;
        rst_n = 1'b0;
        exp_q.delete();
        exp_rdata = '0;
        #1;
        check("arst_mem_data", 128'(mem_data), 128'(0));
        check("arst_mem_cmd", 128'(mem_cmd == CMD_READ || mem_cmd == CMD_WRITE), 128'(0));
        check("arst_busy", 128'(busy), 128'(0));
        check("arst_req_done", 128'(req_done), 128'(0));
        check("arst_mem_addr", 128'(mem_addr), 128'(0));
        check("arst_rdata", rdata, 128'(0));
        n = 0;
        while (!stub_busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) fail("stub_response_timeout", "stub never started its response");
        repeat (2) @(negedge clk);
        push_exp(1, 1'b1, 15'h20, XLINE, 1'b0);
        rst_n = 1'b1;
        n = 0;
        while (stub_busy && n < 20) begin
            @(negedge clk);
            check("no_grant_during_response", 128'(busy), 128'(0));
            n++;
        end
        drain(300);
        check("rewrite_landed", mem[32], XLINE);

        // Valid dropped and request fields changed 5 cycles after grant
        request(0, 1'b0, 15'h10, WLINE, 1'b0);
        wait_issue(20);
        repeat (4) @(negedge clk);
        req_valid[0]    = 1'b0;
        req_write[0]    = 1'b1;
        req_addr[14:0]  = 15'd3;
        repeat (50) @(negedge clk);
        check("addr_latched", 128'(mem_addr), 128'(15'h10));
        drain(300);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
